// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
// The state enum, the smallest legal ratio and the ratio range check live here.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    localparam logic [31:0] DIV_MIN = 32'd2;

    // A ratio of 0 or 1 cannot produce a 50% divided clock, so it is rejected.
    function automatic logic div_valid(input logic [31:0] n, input logic [31:0] div_max);
        return (n >= DIV_MIN) && (n <= div_max);
    endfunction

endpackage

// File: rtl/half_cycle_stretch.sv
// Holds the only negedge flop of the divider. For odd ratios it stretches the
// high phase by half a source cycle, which makes the duty cycle exactly 50%.
module half_cycle_stretch (
    input  logic clk,
    input  logic rst_n,
    input  logic p_in,
    input  logic odd_en,
    output logic clk_out
);

    logic n_q;

    always_ff @(negedge clk) begin
        if (!rst_n) n_q <= 1'b0;
        else        n_q <= p_in & odd_en;
    end

    assign clk_out = p_in | n_q;

endmodule

// File: rtl/clk_div_sched.sv
// Clock-divider controller: 50% duty output for any ratio >= 2, with start/stop
// and ratio changes taking effect only at period boundaries so div_out never glitches.
import clk_div_pkg::*;

module clk_div_sched #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 5,
    parameter int DIV_MAX     = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             period_tick,
    output logic             active,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] div_q, div_nx;
    logic [CNT_W-1:0] pend_div;
    logic             pending, pending_nx;
    logic             p_q, p_nx;
    logic             err_q;
    logic             xfer, ratio_ok, running, last;

    assign running  = (state != ST_STOP);
    assign last     = running && (cnt == div_q - 1'b1);
    assign xfer     = cfg_valid && cfg_ready;
    assign ratio_ok = div_valid(32'(cfg_div), 32'(DIV_MAX));

    // Ratio bookkeeping: a ratio accepted while running waits for the wrap,
    // even when it arrives in the wrap cycle itself.
    always_comb begin
        div_nx     = div_q;
        pending_nx = pending;
        if (last && pending) begin
            div_nx     = pend_div;
            pending_nx = 1'b0;
        end
        if (xfer && ratio_ok) begin
            if (running) pending_nx = 1'b1;
            else         div_nx     = cfg_div;
        end
    end

    // Run control: stopping is only ever committed at a wrap, so the last
    // period always completes and en can cancel a stop without a phase jump.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_STOP: begin
                cnt_nx = '0;
                if (en) state_nx = ST_RUN;
            end
            ST_RUN: begin
                cnt_nx = last ? '0 : cnt + 1'b1;
                if (!en) state_nx = last ? ST_STOP : ST_STOPPING;
            end
            ST_STOPPING: begin
                cnt_nx = last ? '0 : cnt + 1'b1;
                if (en)        state_nx = ST_RUN;
                else if (last) state_nx = ST_STOP;
            end
            default: begin
                state_nx = ST_STOP;
                cnt_nx   = '0;
            end
        endcase
        p_nx = (state_nx != ST_STOP) && (cnt_nx < (div_nx >> 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_STOP;
            cnt      <= '0;
            div_q    <= DIV_RST;
            pend_div <= '0;
            pending  <= 1'b0;
            p_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div_q   <= div_nx;
            pending <= pending_nx;
            p_q     <= p_nx;
            err_q   <= xfer && !ratio_ok;
            if (xfer && ratio_ok && running) pend_div <= cfg_div;
        end
    end

    half_cycle_stretch u_stretch (
        .clk     (clk),
        .rst_n   (rst_n),
        .p_in    (p_q),
        .odd_en  (div_q[0]),
        .clk_out (div_out)
    );

    assign cfg_ready   = !pending;
    assign cfg_err     = err_q;
    assign period_tick = running && (cnt == '0);
    assign active      = running;
    assign cur_div     = div_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: a half-cycle-resolution model of the divided
// clock is compared against the DUT every cycle, plus literal spot checks.
module tb_clk_div_sched;

    localparam int CNT_W       = 16;
    localparam int DIV_DEFAULT = 5;
    localparam int DIV_MAX     = 65535;

    logic             clk = 1'b0;
    logic             rst_n, en, cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready, cfg_err, div_out, period_tick, active;
    logic [CNT_W-1:0] cur_div;

    int tests = 0;
    int fails = 0;

    clk_div_sched #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT), .DIV_MAX(DIV_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .div_out     (div_out),
        .period_tick (period_tick),
        .active      (active),
        .cur_div     (cur_div)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the divider is either on or off; when on it sits at position m_pos
    // of an m_n-cycle period, and in half-cycle h (0..2N-1) the output is high iff h < N.
    // It only stops at a wrap where en is low; a ratio accepted while on waits for a wrap.
    bit m_on, m_has, m_err, m_skip, m_started;
    int m_pos, m_n, m_pend;
    bit s_en, s_v, s_r, s_xfer, s_ok, s_last;
    int s_d;

    always @(posedge clk) begin
        s_en = en; s_v = cfg_valid; s_r = rst_n; s_d = int'(cfg_div);
        m_skip = !s_r;
        if (!s_r) begin
            m_on = 0; m_pos = 0; m_n = DIV_DEFAULT; m_has = 0; m_pend = 0; m_err = 0;
            m_started = 1;
        end else begin
            s_xfer = s_v && !m_has;
            s_ok   = (s_d >= 2) && (s_d <= DIV_MAX);
            s_last = m_on && (m_pos == m_n - 1);
            m_err  = s_xfer && !s_ok;
            if (s_last && m_has) begin m_n = m_pend; m_has = 0; end
            if (s_xfer && s_ok) begin
                if (m_on) begin m_pend = s_d; m_has = 1; end
                else m_n = s_d;
            end
            if (!m_on) begin
                if (s_en) begin m_on = 1; m_pos = 0; end
            end else if (s_last) begin
                m_pos = 0; m_on = s_en;
            end else begin
                m_pos++;
            end
        end
        #1;
        if (m_started) begin
            chk("active", 32'(active), 32'(m_on));
            chk("period_tick", 32'(period_tick), 32'(m_on && m_pos == 0));
            chk("cur_div", 32'(cur_div), 32'(m_n));
            chk("cfg_ready", 32'(cfg_ready), 32'(!m_has));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
            if (!m_skip) chk("div_out_first_half", 32'(div_out), 32'(m_on && (2 * m_pos < m_n)));
        end
    end

    always @(negedge clk) begin
        #1;
        if (m_started) chk("div_out_second_half", 32'(div_out), 32'(m_on && (2 * m_pos + 1 < m_n)));
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic offer(input int d);
        cfg_div   = CNT_W'(d);
        cfg_valid = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input int lim);
        int k = 0;
        while (!cfg_ready && k < lim) begin cyc(1); k++; end
        if (!cfg_ready) begin tests++; fails++; $display("FAIL wait_ready timeout actual=0 expected=1"); end
    endtask

    task automatic wait_tick(input int lim);
        int k = 0;
        do begin cyc(1); k++; end while (!period_tick && k < lim);
        if (!period_tick) begin tests++; fails++; $display("FAIL wait_tick timeout actual=0 expected=1"); end
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (active && k < lim) begin cyc(1); k++; end
        if (active) begin tests++; fails++; $display("FAIL wait_idle timeout actual=1 expected=0"); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        cyc(2);
        chk("rst_cur_div", 32'(cur_div), 32'd5);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_div_out", 32'(div_out), 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Default ratio 5: starts one cycle after en.
        en = 1'b1;
        cyc(1);
        chk("start_tick", 32'(period_tick), 32'd1);
        chk("start_div_out", 32'(div_out), 32'd1);
        cyc(11);

        // Stop, program 4 while stopped, restart.
        en = 1'b0;
        wait_idle(20);
        offer(4);
        chk("stop_cfg_cur_div", 32'(cur_div), 32'd4);
        en = 1'b1;
        cyc(9);

        // Go to N=3, then request 6 at cnt=1 of an N=3 period.
        offer(3);
        wait_ready(20);
        wait_tick(20);
        cyc(1);
        offer(6);
        chk("mid_cfg_ready_low", 32'(cfg_ready), 32'd0);
        chk("mid_cfg_old_div", 32'(cur_div), 32'd3);
        wait_ready(20);
        chk("mid_cfg_new_div", 32'(cur_div), 32'd6);
        chk("model_n6", 32'(m_n), 32'd6);
        cyc(7);

        // Out-of-range ratios are rejected with a pulse each.
        offer(1);
        chk("err_div1", 32'(cfg_err), 32'd1);
        offer(0);
        chk("err_div0", 32'(cfg_err), 32'd1);
        cyc(1);
        chk("err_clear", 32'(cfg_err), 32'd0);
        chk("err_cur_div", 32'(cur_div), 32'd6);

        // N=7: drop en at cnt=1, let the period finish; then cancel a stop.
        offer(7);
        wait_ready(20);
        wait_tick(20);
        cyc(1);
        en = 1'b0;
        wait_idle(20);
        chk("stopped_div_out", 32'(div_out), 32'd0);
        chk("stopped_active", 32'(active), 32'd0);
        en = 1'b1;
        cyc(4);
        en = 1'b0;
        cyc(2);
        chk("stopping_active", 32'(active), 32'd1);
        en = 1'b1;
        cyc(16);

        // Reset in the high phase with a ratio pending.
        wait_tick(20);
        offer(3);
        chk("pend_before_rst", 32'(cfg_ready), 32'd0);
        rst_n = 1'b0;
        cyc(2);
        chk("rst_mid_div_out", 32'(div_out), 32'd0);
        chk("rst_mid_cur_div", 32'(cur_div), 32'd5);
        chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
        chk("rst_mid_active", 32'(active), 32'd0);
        chk("model_n5", 32'(m_n), 32'd5);
        rst_n = 1'b1;
        en = 1'b0;
        cyc(2);

        // Ratio and en together in STOP: first period already uses N=2.
        cfg_div = CNT_W'(2); cfg_valid = 1'b1; en = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
        chk("cfg_en_cur_div", 32'(cur_div), 32'd2);
        chk("cfg_en_tick", 32'(period_tick), 32'd1);
        cyc(8);
        en = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
